// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared types for the decode-stage immediate generator.
//               imm_sel_e : immediate format select. Encodings 6 and 7 are
//                           undefined and are flagged as illegal.
//               c_instr_w : instruction word width.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    localparam int c_instr_w = 32;
    localparam int c_sel_w   = 3;

    typedef enum logic [c_sel_w-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4,
        IMM_Z = 3'd5
    } imm_sel_e;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Combinational immediate extraction and extension to XLEN.
// Ports       : instr   (in)  raw 32-bit instruction
//               sel     (in)  immediate format, imm_sel_e encoding
//               imm     (out) sign/zero-extended immediate, XLEN bits
//               illegal (out) sel is not a defined format (imm forced to 0)
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [c_instr_w-1:0] instr,
    input  logic [c_sel_w-1:0]   sel,
    output logic [XLEN-1:0]      imm,
    output logic                 illegal
);

    logic [31:0] w_raw;     // immediate assembled at 32 bits
    logic        w_zext;    // zero-extend instead of sign-extend
    logic        w_sign;
    logic        w_unused_opcode;

    assign w_sign = instr[31];

    // The opcode field never contributes to any immediate.
    assign w_unused_opcode = ^instr[6:0];

    always_comb begin
        w_raw   = 32'd0;
        w_zext  = 1'b0;
        illegal = 1'b0;
        case (sel)
            IMM_I: w_raw = {{20{w_sign}}, instr[31:20]};
            IMM_S: w_raw = {{20{w_sign}}, instr[31:25], instr[11:7]};
            IMM_B: w_raw = {{19{w_sign}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_J: w_raw = {{11{w_sign}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            IMM_U: w_raw = {instr[31:12], 12'd0};
            IMM_Z: begin
                w_raw  = {27'd0, instr[19:15]};
                w_zext = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Every 32-bit form is already correctly signed at bit 31, so a single
    // sign extension covers RV64 U-type as well as the other signed formats.
    always_comb begin
        if (w_zext) begin
            imm = XLEN'(w_raw);
        end else begin
            imm = XLEN'($signed(w_raw));
        end
    end

endmodule : imm_decode
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Pipelined immediate generator with PC-relative target.
//               One-cycle latency; output register backed by a single skid
//               entry so in_ready is registered and independent of out_ready.
// Ports       : clk, rst_n                    clock / async active-low reset
//               in_valid, in_ready            upstream handshake
//               in_instr, in_sel, in_pc       instruction, format, PC
//               in_tag                        opaque sideband tag
//               out_valid, out_ready          downstream handshake
//               out_imm, out_tgt              immediate and pc + imm
//               out_illegal, out_tag          undefined-format flag, tag
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [c_instr_w-1:0] in_instr,
    input  logic [c_sel_w-1:0]   in_sel,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [TAGW-1:0]      in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_tgt,
    output logic                 out_illegal,
    output logic [TAGW-1:0]      out_tag
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        logic            illegal;
        logic [TAGW-1:0] tag;
    } imm_item_t;

    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_accept;
    imm_item_t       w_new;

    imm_item_t       r_out;
    imm_item_t       r_skid;
    logic            r_out_valid;
    logic            r_skid_valid;
    logic            r_in_ready;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (in_instr),
        .sel     (in_sel),
        .imm     (w_imm),
        .illegal (w_illegal)
    );

    always_comb begin
        w_new         = '0;
        w_new.imm     = w_imm;
        w_new.tgt     = in_pc + w_imm;   // wraps modulo 2^XLEN
        w_new.illegal = w_illegal;
        w_new.tag     = in_tag;
    end

    assign w_accept = in_valid && r_in_ready;

    // The skid entry only fills while the output is stalled, and in_ready is
    // low whenever it is full, so an accept never coincides with a full skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (r_skid_valid) begin
            if (out_ready) begin
                r_out        <= r_skid;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end
        end else if (!r_out_valid || out_ready) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out <= w_new;
            end
        end else if (w_accept) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out.imm;
    assign out_tgt     = r_out.tgt;
    assign out_illegal = r_out.illegal;
    assign out_tag     = r_out.tag;

endmodule : imm_gen_pipe
`default_nettype wire
